// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse integration path: index width, header layout,
// reader FSM encoding and the window-length helper.
package pulse_pkg;

    localparam int IDX_W       = 16;
    localparam int NORM_W      = 5;
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_CNT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } state_t;

    // Inclusive window length; an inverted window is empty and a full
    // 0..65535 window saturates to the largest representable count.
    function automatic logic [IDX_W-1:0] frame_len(input logic [IDX_W-1:0] first_idx,
                                                   input logic [IDX_W-1:0] last_idx);
        logic [IDX_W:0] span;
        span = {1'b0, last_idx} - {1'b0, first_idx} + (IDX_W+1)'(1);
        if (last_idx < first_idx) begin
            return '0;
        end
        return span[IDX_W] ? '1 : span[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/pulse_frame_reader_axis_out_reg.sv
// Single registered AXI-Stream output stage; accepts a new word whenever it is
// empty or its current word is being taken downstream.
module axis_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    assign in_ready = ~m_axis_tvalid | m_axis_tready;

    always_ff @(posedge aclk) begin
        // NOTE: registered state uses <= so every flop samples pre-edge values.
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (in_ready) begin
            m_axis_tvalid <= in_valid;
            if (in_valid) begin
                m_axis_tdata <= in_data;
                m_axis_tlast <= in_last;
            end
        end
    end

endmodule

// File: rtl/pulse_frame_reader.sv
// Frames the integrated-pulse stream as header, shifted window samples, tlast.
// Define PULSE_FRAME_TRAILER_EN to append an XOR checksum word to each frame.
module pulse_frame_reader
    import pulse_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    input  logic [IDX_W-1:0]           start_index,
    input  logic [IDX_W-1:0]           end_index,
    input  logic [NORM_W-1:0]          norm_shift,
    output logic [31:0]                frame_count
);

`ifdef PULSE_FRAME_TRAILER_EN
    localparam state_t AFTER_LAST = TRAILER;
`else
    localparam state_t AFTER_LAST = IDLE;
`endif

    state_t                      state;
    logic [IDX_W-1:0]            len_q;
    logic [IDX_W-1:0]            word_cnt;
    logic [NORM_W-1:0]           shift_q;
    logic [AXIS_DATA_WIDTH-1:0]  shifted;
    logic [AXIS_DATA_WIDTH-1:0]  st_data;
    logic                        st_valid;
    logic                        st_last;
    logic                        st_ready;
    logic                        hs_last;
    logic                        data_fire;
    logic                        last_sample;
    logic [31:0]                 frame_count_nxt;
`ifdef PULSE_FRAME_TRAILER_EN
    logic [AXIS_DATA_WIDTH-1:0]  csum_q;
`endif

    assign shifted         = $signed(s_axis_tdata) >>> shift_q;
    assign hs_last         = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    // The header must report a frame whose tlast handshakes in this same cycle.
    assign frame_count_nxt = frame_count + 32'(hs_last);
    assign s_axis_tready   = (state == DATA) & st_ready;
    assign data_fire       = s_axis_tready & s_axis_tvalid;
    assign last_sample     = (word_cnt + IDX_W'(1)) == len_q;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        st_valid = 1'b0;
        st_data  = '0;
        st_last  = 1'b0;
        case (state)
            HEADER: begin
                st_valid = 1'b1;
                st_data[HDR_LEN_LSB +: IDX_W] = len_q;
                st_data[HDR_CNT_LSB +: IDX_W] = frame_count_nxt[IDX_W-1:0];
`ifndef PULSE_FRAME_TRAILER_EN
                st_last = (len_q == '0);
`endif
            end
            DATA: begin
                st_valid = s_axis_tvalid;
                st_data  = shifted;
`ifndef PULSE_FRAME_TRAILER_EN
                st_last  = last_sample;
`endif
            end
`ifdef PULSE_FRAME_TRAILER_EN
            TRAILER: begin
                st_valid = 1'b1;
                st_data  = csum_q;
                st_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            len_q       <= '0;
            shift_q     <= '0;
            word_cnt    <= '0;
            frame_count <= '0;
        end else begin
            frame_count <= frame_count_nxt;
            case (state)
                IDLE: begin
                    // The waiting sample only opens the frame; it is taken in DATA.
                    if (s_axis_tvalid) begin
                        len_q    <= frame_len(start_index, end_index);
                        shift_q  <= norm_shift;
                        word_cnt <= '0;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (st_ready) begin
                        state <= (len_q != '0) ? DATA : AFTER_LAST;
                    end
                end
                DATA: begin
                    if (data_fire) begin
                        word_cnt <= word_cnt + IDX_W'(1);
                        if (last_sample) begin
                            state <= AFTER_LAST;
                        end
                    end
                end
`ifdef PULSE_FRAME_TRAILER_EN
                TRAILER: begin
                    if (st_ready) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PULSE_FRAME_TRAILER_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            csum_q <= '0;
        end else if (state == HEADER && st_ready) begin
            csum_q <= '0;
        end else if (data_fire) begin
            csum_q <= csum_q ^ shifted;
        end
    end
`endif

    axis_out_reg #(
        .DATA_W (AXIS_DATA_WIDTH)
    ) u_out (
        .aclk          (aclk),
        .areset        (areset),
        .in_valid      (st_valid),
        .in_data       (st_data),
        .in_last       (st_last),
        .in_ready      (st_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_pulse_frame_reader.sv
// Self-checking bench for pulse_frame_reader: table of frames plus reset,
// empty-window and saturated-window sequences, checked through a scoreboard.
module tb_pulse_frame_reader;

    localparam int W    = 32;
    localparam int NV   = 6;
    localparam int BOUND = 200;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [15:0]   start_index = '0;
    logic [15:0]   end_index = '0;
    logic [4:0]    norm_shift = '0;
    logic [31:0]   frame_count;

    int total = 0;
    int bad   = 0;
    int frame_exp = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0]        st;
        logic [15:0]        en;
        logic [4:0]         sh;
        int                 n;
        logic [3:0][W-1:0]  samp;
        logic [3:0][W-1:0]  expd;
        logic [3:0]         pat;
    } vec_t;
    vec_t vecs [NV];

    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         prev_last  = 1'b0;

    pulse_frame_reader #(.AXIS_DATA_WIDTH(W)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .start_index   (start_index),
        .end_index     (end_index),
        .norm_shift    (norm_shift),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][W-1:0] w4(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
        logic [3:0][W-1:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic push(input logic [W-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    // Output monitor: pops the scoreboard on every handshake, checks stall hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            #2;
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                          {1'b1, prev_last, prev_data});
                if (m_axis_tvalid && !m_axis_tready)
                    check("s_ready_backpressure", 64'(s_axis_tready), 64'd0);
                if (m_axis_tvalid && m_axis_tready) begin
                    check("scoreboard_has_word", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("out_word", {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    // Drives one frame's samples; returns after all queued words have left.
    task automatic drive(input logic [15:0] st, input logic [15:0] en, input logic [4:0] sh,
                         input int n, input logic [3:0][W-1:0] samp, input logic [3:0] pat);
        int idx = 0;
        int cyc = 0;
        bit first = 1'b1;
        start_index = st;
        end_index   = en;
        norm_shift  = sh;
        while ((first || idx < n || sb.size() != 0) && cyc < BOUND) begin
            @(negedge aclk);
            if (!first) begin
                start_index = 16'($urandom);
                end_index   = 16'($urandom);
                norm_shift  = 5'($urandom);
            end
            s_axis_tvalid = first || (idx < n);
            s_axis_tdata  = (idx < n) ? samp[idx] : 32'hDEAD_BEEF;
            m_axis_tready = pat[cyc % 4];
            first = 1'b0;
            #1;
            if (s_axis_tvalid && s_axis_tready) idx++;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        check("frame_within_bound", 64'(cyc < BOUND), 64'd1);
    endtask

    task automatic run_frame(input logic [15:0] st, input logic [15:0] en, input logic [4:0] sh,
                             input int n, input logic [3:0][W-1:0] samp,
                             input logic [3:0][W-1:0] expd, input logic [3:0] pat);
        logic [W-1:0] x = '0;
        bit trailer = 1'b0;
`ifdef PULSE_FRAME_TRAILER_EN
        trailer = 1'b1;
`endif
        push({16'(frame_exp), 16'(n)}, !trailer && n == 0);
        for (int i = 0; i < n; i++) begin
            push(expd[i], !trailer && i == n - 1);
            x = x ^ expd[i];
        end
        if (trailer) push(x, 1'b1);
        frame_exp++;
        drive(st, en, sh, n, samp, pat);
        check("frame_count", 64'(frame_count), 64'(frame_exp));
    endtask

    // Sends part of a frame, parks one more word behind a stall, then resets.
    task automatic run_partial(input logic [15:0] st, input logic [15:0] en, input logic [4:0] sh,
                               input int n, input logic [3:0][W-1:0] samp,
                               input logic [3:0][W-1:0] expd, input logic [15:0] exp_len);
        push({16'(frame_exp), exp_len}, 1'b0);
        for (int i = 0; i < n; i++) push(expd[i], 1'b0);
        drive(st, en, sh, n, samp, 4'hF);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0000_0055;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        #1;
        check("pre_reset_tvalid", 64'(m_axis_tvalid), 64'd1);
        @(negedge aclk);
        #1;
        check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mid_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_mid_frame_count", 64'(frame_count), 64'd0);
        check("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        frame_exp = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd2,   16'd5,   5'd0,  4, w4(10, 20, 30, 40), w4(10, 20, 30, 40), 4'hF};
        vecs[1] = '{16'd0,   16'd1,   5'd3,  2, w4(32'hFFFF_FFC0, 17, 0, 0),
                    w4(32'hFFFF_FFF8, 32'h0000_0002, 0, 0), 4'hF};
        vecs[2] = '{16'd2,   16'd5,   5'd0,  4, w4(10, 20, 30, 40), w4(10, 20, 30, 40), 4'b1001};
        vecs[3] = '{16'd100, 16'd102, 5'd4,  3, w4(32'h1234_5678, 32'hFFFF_FF00, 32'h0000_000F, 0),
                    w4(32'h0123_4567, 32'hFFFF_FFF0, 32'h0000_0000, 0), 4'b0101};
        vecs[4] = '{16'd10,  16'd11,  5'd31, 2, w4(32'h8000_0000, 32'h7FFF_FFFF, 0, 0),
                    w4(32'hFFFF_FFFF, 32'h0000_0000, 0, 0), 4'b0011};
        vecs[5] = '{16'd0,   16'd1,   5'd0,  2, w4(32'h0F, 32'hF0, 0, 0), w4(32'h0F, 32'hF0, 0, 0), 4'hF};

        repeat (3) @(negedge aclk);
        #1;
        check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset_tlast", 64'(m_axis_tlast), 64'd0);
        check("reset_tdata", 64'(m_axis_tdata), 64'd0);
        check("reset_s_tready", 64'(s_axis_tready), 64'd0);
        check("reset_frame_count", 64'(frame_count), 64'd0);
        areset = 1'b0;

        // Inverted window: header-only frames carrying the running count.
        run_frame(16'd5, 16'd2, 5'd0, 0, '0, '0, 4'hF);
        run_frame(16'd5, 16'd2, 5'd0, 0, '0, '0, 4'hF);

        for (int i = 0; i < NV; i++)
            run_frame(vecs[i].st, vecs[i].en, vecs[i].sh, vecs[i].n,
                      vecs[i].samp, vecs[i].expd, vecs[i].pat);

        run_partial(16'd2, 16'd5, 5'd0, 2, w4(10, 20, 0, 0), w4(10, 20, 0, 0), 16'd4);
        run_frame(vecs[0].st, vecs[0].en, vecs[0].sh, vecs[0].n,
                  vecs[0].samp, vecs[0].expd, vecs[0].pat);

        // Full 0..65535 window saturates the reported length.
        run_partial(16'd0, 16'hFFFF, 5'd1, 2, w4(6, 32'hFFFF_FFFA, 0, 0),
                    w4(3, 32'hFFFF_FFFD, 0, 0), 16'hFFFF);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
